// File: rtl/alu_nbit_pipe.sv
// alu_nbit_pipe: two-stage WIDTH-bit ALU with valid/ready on both sides.
// Stage 1 captures the operation on accept; stage 2 holds the computed
// Result and status flags until downstream consumes them.
module alu_nbit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative,
    output logic             Illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        logic             zero;
        logic             neg;
        logic             ill;
    } alu_res_t;

    // SUB and SLT share the adder with b inverted and a forced carry-in of 1;
    // SLT is the sign of the true difference, i.e. N ^ V of that sum.
    function automatic alu_res_t alu_eval(input logic [3:0]       op,
                                          input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic             cin);
        alu_res_t         r;
        logic             is_sub;
        logic [WIDTH-1:0] y_eff;
        logic             c_eff;
        logic [WIDTH:0]   sum;
        logic             ovf;
        r      = '0;
        is_sub = (op == OP_SUB) || (op == OP_SLT);
        y_eff  = is_sub ? ~y : y;
        c_eff  = (op == OP_ADD) ? cin : is_sub;
        sum    = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};
        ovf    = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        case (op)
            OP_AND: r.res = x & y;
            OP_OR:  r.res = x | y;
            OP_NOR: r.res = ~(x | y);
            OP_ADD, OP_SUB: begin
                r.res = sum[WIDTH-1:0];
                r.co  = sum[WIDTH];
                r.ov  = ovf;
            end
            OP_SLT: r.res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: r.ill = 1'b1;
        endcase
        // Zero/Negative only describe results of legal ops.
        r.zero = ~r.ill & (r.res == '0);
        r.neg  = ~r.ill & r.res[WIDTH-1];
        return r;
    endfunction

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] a_p1_q, a_p1_d;
    logic [WIDTH-1:0] b_p1_q, b_p1_d;
    logic             cin_p1_q, cin_p1_d;
    logic [3:0]       op_p1_q, op_p1_d;

    logic             vld_p2_q, vld_p2_d;
    alu_res_t         res_p2_q, res_p2_d;

    logic             adv_p1;
    logic             accept;

    // Handshake: stage 1 moves on when stage 2 is empty or draining this cycle.
    always_comb begin
        adv_p1   = vld_p1_q & (~vld_p2_q | out_ready);
        in_ready = ~vld_p1_q | adv_p1;
        accept   = in_valid & in_ready;
    end

    // Stage 1 next state: capture operands on accept, otherwise hold.
    always_comb begin
        vld_p1_d = vld_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        cin_p1_d = cin_p1_q;
        op_p1_d  = op_p1_q;
        if (accept) begin
            vld_p1_d = 1'b1;
            a_p1_d   = a;
            b_p1_d   = b;
            cin_p1_d = CarryIn;
            op_p1_d  = ALUop;
        end else if (adv_p1) begin
            vld_p1_d = 1'b0;
        end
    end

    // Stage 2 next state: load the evaluated op on advance, clear on emit.
    always_comb begin
        vld_p2_d = vld_p2_q & ~out_ready;
        res_p2_d = res_p2_q;
        if (adv_p1) begin
            vld_p2_d = 1'b1;
            res_p2_d = alu_eval(op_p1_q, a_p1_q, b_p1_q, cin_p1_q);
        end
    end

    // ---- stage 1 boundary: control state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_p1_q <= 1'b0;
        else       vld_p1_q <= vld_p1_d;
    end

    // Stage 1 operand registers; contents are don't-care while vld_p1_q is low.
    always_ff @(posedge clk) begin
        a_p1_q   <= a_p1_d;
        b_p1_q   <= b_p1_d;
        cin_p1_q <= cin_p1_d;
        op_p1_q  <= op_p1_d;
    end

    // ---- stage 2 boundary: result and flags, cleared so outputs read 0 in reset ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
        end
    end

    // Output mapping straight from stage 2 registers.
    always_comb begin
        out_valid = vld_p2_q;
        Result    = res_p2_q.res;
        CarryOut  = res_p2_q.co;
        Overflow  = res_p2_q.ov;
        Zero      = res_p2_q.zero;
        Negative  = res_p2_q.neg;
        Illegal   = res_p2_q.ill;
    end

endmodule
